// File: rtl/tx_arbiter.sv
// Round-robin scheduler that shares one UART Tx unit between N byte requesters.
// It latches the winner's byte and config, handshakes with the unit, and returns Ack or Err.
module tx_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [N-1:0]   Req,
  input  logic [8*N-1:0] ReqData,
  input  logic [2*N-1:0] ReqParity,
  input  logic [2*N-1:0] ReqBaud,
  input  logic [N-1:0]   ReqStop,
  input  logic [N-1:0]   ReqLen,
  output logic [N-1:0]   Grant,
  output logic [N-1:0]   Ack,
  output logic [N-1:0]   Err,
  output logic           Busy,
  output logic [7:0]     TxData,
  output logic [1:0]     TxParityType,
  output logic [1:0]     TxBaudRate,
  output logic           TxStopBits,
  output logic           TxDataLength,
  output logic           TxSend,
  input  logic           TxActive,
  input  logic           TxDone
);
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SETUP, START, BUSY, DONE, FAIL} state_t;

  state_t        state;
  logic [PW-1:0] ptr, curIdx, winIdx, nextPtr;
  logic [N-1:0]  winHot;
  logic          found;
  logic [7:0]    winData;
  logic [1:0]    winParity, winBaud;
  logic          winStop, winLen;
  logic [CW-1:0] cnt;
  int            idx;

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    found     = 1'b0;
    winIdx    = '0;
    winHot    = '0;
    winData   = '0;
    winParity = '0;
    winBaud   = '0;
    winStop   = 1'b0;
    winLen    = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && Req[idx]) begin
        found       = 1'b1;
        winIdx      = PW'(idx);
        winHot[idx] = 1'b1;
        winData     = ReqData[8*idx +: 8];
        winParity   = ReqParity[2*idx +: 2];
        winBaud     = ReqBaud[2*idx +: 2];
        winStop     = ReqStop[idx];
        winLen      = ReqLen[idx];
      end
    end
  end

  assign nextPtr = (curIdx == PW'(N - 1)) ? '0 : curIdx + 1'b1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      ptr          <= '0;
      curIdx       <= '0;
      cnt          <= '0;
      Grant        <= '0;
      Ack          <= '0;
      Err          <= '0;
      Busy         <= 1'b0;
      TxData       <= '0;
      TxParityType <= '0;
      TxBaudRate   <= '0;
      TxStopBits   <= 1'b0;
      TxDataLength <= 1'b0;
      TxSend       <= 1'b0;
    end else begin
      Ack <= '0;
      Err <= '0;
      case (state)
        IDLE: if (found) begin
          Grant        <= winHot;
          curIdx       <= winIdx;
          TxData       <= winData;
          TxParityType <= winParity;
          TxBaudRate   <= winBaud;
          TxStopBits   <= winStop;
          TxDataLength <= winLen;
          Busy         <= 1'b1;
          state        <= SETUP;
        end
        // Data/config already stable for a cycle; now raise Send.
        SETUP: begin
          TxSend <= 1'b1;
          cnt    <= '0;
          state  <= START;
        end
        START: begin
          cnt <= (cnt == CW'(TIMEOUT)) ? cnt : cnt + 1'b1;
          if (TxActive) begin
            TxSend <= 1'b0;
            state  <= BUSY;
          end else if (cnt == CW'(TIMEOUT)) begin
            TxSend <= 1'b0;
            Err    <= Grant;
            Grant  <= '0;
            ptr    <= nextPtr;
            state  <= FAIL;
          end
        end
        BUSY: if (!TxActive && TxDone) begin
          Ack   <= Grant;
          Grant <= '0;
          ptr   <= nextPtr;
          state <= DONE;
        end
        DONE, FAIL: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: stubbed Tx unit, round-robin vector table, scoreboard of
// expected Ack/Err and transmitted frames, plus reset/timeout/mid-frame sequences.
module tb_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 15;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [3:0]  Req;
  logic [31:0] ReqData;
  logic [7:0]  ReqParity, ReqBaud;
  logic [3:0]  ReqStop, ReqLen;
  logic [3:0]  Grant, Ack, Err;
  logic        Busy, TxStopBits, TxDataLength, TxSend;
  logic [7:0]  TxData;
  logic [1:0]  TxParityType, TxBaudRate;
  logic        TxActive = 1'b0;
  logic        TxDone   = 1'b0;

  tx_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .ReqData(ReqData),
    .ReqParity(ReqParity), .ReqBaud(ReqBaud), .ReqStop(ReqStop), .ReqLen(ReqLen),
    .Grant(Grant), .Ack(Ack), .Err(Err), .Busy(Busy), .TxData(TxData),
    .TxParityType(TxParityType), .TxBaudRate(TxBaudRate), .TxStopBits(TxStopBits),
    .TxDataLength(TxDataLength), .TxSend(TxSend), .TxActive(TxActive), .TxDone(TxDone)
  );

  always #5 Clock = ~Clock;

  typedef struct { logic isErr; logic [3:0] who; logic [13:0] frame; } exp_t;
  typedef struct { logic [3:0] req; logic [3:0] expGrant; } vec_t;

  exp_t        sb[$];
  exp_t        e;
  int          nVec = 0, nMis = 0;
  bit          stubEn = 1'b1;
  int          stSt = 0, stCnt = 0;
  logic [13:0] sent = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] frameOf(int w, logic [7:0] b);
    return {b, ReqParity[2*w +: 2], ReqBaud[2*w +: 2], ReqStop[w], ReqLen[w]};
  endfunction

  function automatic int idxOf(logic [3:0] g);
    int r = 0;
    for (int k = 0; k < 4; k++) if (g[k]) r = k;
    return r;
  endfunction

  // Tx unit stub: accepts Send, stays active for a few cycles, then pulses Done.
  always @(negedge Clock) begin
    case (stSt)
      0: begin
        TxDone = 1'b0;
        if (stubEn && TxSend) begin
          sent     = {TxData, TxParityType, TxBaudRate, TxStopBits, TxDataLength};
          TxActive = 1'b1;
          stCnt    = 0;
          stSt     = 1;
        end
      end
      1: begin
        stCnt++;
        if (stCnt == 4) begin
          TxActive = 1'b0;
          TxDone   = 1'b1;
          stSt     = 2;
        end
      end
      default: begin
        TxDone = 1'b0;
        stSt   = 0;
      end
    endcase
  end

  // Scoreboard: every Ack/Err pulse must match the oldest expectation.
  always @(negedge Clock) begin
    if (|Ack || |Err) begin
      if (sb.size() == 0) begin
        nVec++;
        nMis++;
        $display("FAIL unexpected_pulse: Ack=%b Err=%b want none", Ack, Err);
      end else begin
        e = sb.pop_front();
        check("ack", 32'(Ack), e.isErr ? 32'd0 : 32'(e.who));
        check("err", 32'(Err), e.isErr ? 32'(e.who) : 32'd0);
        if (!e.isErr) check("frame", 32'(sent), 32'(e.frame));
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge Clock);
  endtask

  task automatic doReset();
    Reset = 1'b1;
    Req   = '0;
    tick(2);
    Reset = 1'b0;
  endtask

  task automatic waitGrant(output int n);
    n = 0;
    while (Grant == 4'b0 && n < 50) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 50) begin nVec++; nMis++; $display("FAIL grant_timeout: got none want grant"); end
  endtask

  task automatic waitPulse(output int n);
    n = 0;
    while (!(|Ack || |Err) && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 200) begin nVec++; nMis++; $display("FAIL pulse_timeout: got none want Ack/Err"); end
  endtask

  task automatic waitSend(logic lvl);
    int n = 0;
    while (TxSend !== lvl && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 100) begin nVec++; nMis++; $display("FAIL send_timeout: got %b want %b", TxSend, lvl); end
  endtask

  vec_t vt[8];
  int   n, w;

  initial begin
    vt = '{'{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100}, '{4'b1111, 4'b1000},
           '{4'b1111, 4'b0001}, '{4'b1010, 4'b0010}, '{4'b1010, 4'b1000}, '{4'b1010, 4'b0010}};
    Req       = '0;
    ReqData   = 32'h4433_22A5;
    ReqParity = 8'b00_11_10_01;
    ReqBaud   = 8'b01_00_11_10;
    ReqStop   = 4'b1010;
    ReqLen    = 4'b0101;
    Reset     = 1'b1;
    tick(1);
    doReset();
    check("rst_outs", {Grant, Ack, Err, 3'b0, Busy, 3'b0, TxSend}, 32'd0);
    check("rst_tx", {18'd0, TxData, TxParityType, TxBaudRate, TxStopBits, TxDataLength}, 32'd0);

    // Single request: Grant/TxData one cycle ahead of TxSend.
    Req = 4'b0001;
    sb.push_back('{1'b0, 4'b0001, frameOf(0, 8'hA5)});
    waitGrant(n);
    check("t1_grant", 32'(Grant), 32'h1);
    check("t1_data", 32'(TxData), 32'hA5);
    check("t1_cfg", {28'd0, TxParityType, TxBaudRate}, 32'b0110);
    check("t1_send_lo", 32'(TxSend), 32'd0);
    tick();
    check("t1_send_hi", 32'(TxSend), 32'd1);
    waitPulse(n);
    Req = '0;
    tick(3);
    check("t1_idle", {Grant, 3'b0, Busy}, 32'd0);

    // Round-robin table, Req held level across frames.
    doReset();
    ReqData = 32'h4433_2211;
    for (int i = 0; i < 8; i++) begin
      Req = vt[i].req;
      w = idxOf(vt[i].expGrant);
      sb.push_back('{1'b0, vt[i].expGrant, frameOf(w, ReqData[8*w +: 8])});
      waitGrant(n);
      if (i > 0) check("b2b_gap", 32'(n), 32'd2);
      check("rr_grant", 32'(Grant), 32'(vt[i].expGrant));
      waitPulse(n);
    end
    Req = '0;

    // Mid-frame: data changes during START, Req drops during BUSY.
    tick(3);
    ReqData[7:0] = 8'h5A;
    Req = 4'b0001;
    sb.push_back('{1'b0, 4'b0001, frameOf(0, 8'h5A)});
    waitSend(1'b1);
    ReqData[7:0] = 8'hFF;
    waitSend(1'b0);
    Req = '0;
    waitPulse(n);
    ReqData[7:0] = 8'h11;

    // Timeout with TxActive stuck low.
    tick(3);
    stubEn = 1'b0;
    Req = 4'b0100;
    sb.push_back('{1'b1, 4'b0100, 14'd0});
    waitSend(1'b1);
    n = 0;
    while (TxSend && n < 100) begin
      n++;
      @(negedge Clock);
    end
    check("to_send_len", 32'(n), 32'(TO + 1));
    check("to_err_now", 32'(Err), 32'b0100);
    Req = '0;
    stubEn = 1'b1;
    tick(3);
    Req = 4'b1111;
    sb.push_back('{1'b0, 4'b1000, frameOf(3, 8'h44)});
    waitGrant(n);
    check("to_ptr_next", 32'(Grant), 32'b1000);
    waitPulse(n);
    Req = '0;

    // Reset while BUSY: everything drops, no pulse, pointer back to 0.
    tick(3);
    Req = 4'b0001;
    waitSend(1'b1);
    waitSend(1'b0);
    Reset = 1'b1;
    Req = '0;
    tick();
    check("rb_outs", {Grant, 3'b0, Busy, 3'b0, TxSend}, 32'd0);
    Reset = 1'b0;
    tick(10);
    Req = 4'b1111;
    sb.push_back('{1'b0, 4'b0001, frameOf(0, 8'h11)});
    waitGrant(n);
    check("rb_ptr0", 32'(Grant), 32'b0001);
    waitPulse(n);
    Req = '0;
    tick(3);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin transmit scheduler that shares one UART transmit unit between `N` byte requesters. It sits directly in front of the Tx top level. It captures the winning requester's byte and frame configuration, drives the unit's data, config and `Send` inputs, and tracks the unit's active and done flags. When the frame completes it returns a one-cycle acknowledge, or an error pulse on start timeout, to the requester it served.

## Interface
- `N`, 4 — number of requesters (2..8).
- `TIMEOUT`, 1023 — maximum clock cycles `TxSend` is held waiting for `TxActive` before the frame is abandoned; must be ≥ 1.
- `Clock`  in  1  — single system clock; all logic on rising edge.
- `Reset`  in  1  — synchronous, active-high; one clock; reset is synchronous and active-high.
- `Req`  in  N  — per-requester level request; held until that requester's `Ack` or `Err`.
- `ReqData`  in  8*N  — packed bytes; byte i at [8i+7:8i].
- `ReqParity`  in  2*N  — per-requester parity type.
- `ReqBaud`  in  2*N  — per-requester baud select.
- `ReqStop`  in  N  — per-requester stop-bit select.
- `ReqLen`  in  N  — per-requester data-length select.
- `Grant`  out  N  — one-hot; requester currently owning the transmitter.
- `Ack`  out  N  — one-cycle pulse; frame for requester i completed.
- `Err`  out  N  — one-cycle pulse; frame for requester i abandoned on timeout.
- `Busy`  out  1  — high in any state other than IDLE.
- `TxData`  out  8  — byte to the Tx unit.
- `TxParityType`, `TxBaudRate`  out  2 each — config to the Tx unit.
- `TxStopBits`, `TxDataLength`  out  1 each — config to the Tx unit.
- `TxSend`  out  1  — send request to the Tx unit.
- `TxActive`  in  1  — Tx unit active flag.
- `TxDone`  in  1  — Tx unit done flag.

## Operation
- All outputs are registered.
- Reset values:
  - `Grant`, `Ack`, `Err`, `TxData`, all `Tx*` config outputs: 0.
  - `TxSend`, `Busy`: 0.
  - Round-robin pointer: 0. State: IDLE.
- Reset mid-frame immediately drops `TxSend` and `Grant`; no `Ack` or `Err` is issued.
- Arbitration:
  - Search starts at the pointer and wraps modulo `N`; the first requester with `Req` high wins.
  - After `Ack` or `Err` for requester i, the pointer becomes (i+1) mod `N`. Wrap from `N-1` goes to 0.
- States:
  - IDLE: if any `Req` is high, latch the winner's byte and config into the `Tx*` outputs, set `Grant`, go to SETUP. Otherwise stay in IDLE.
  - SETUP: holds data and config stable for one cycle so the Tx unit's input register captures them. Go to START.
  - START: `TxSend`=1 and the timeout counter increments each cycle.
    - `TxActive`=1 → go to BUSY.
    - Counter reaches `TIMEOUT` → go to FAIL.
  - BUSY: `TxSend`=0. Exit to DONE when `TxActive`=0 and `TxDone`=1.
  - DONE: `Ack[i]`=1 for one cycle, `Grant` cleared, pointer advanced, go to IDLE.
  - FAIL: `Err[i]`=1 for one cycle, `Grant` cleared, pointer advanced, go to IDLE.
- Latched byte and config do not change between IDLE exit and DONE/FAIL, regardless of the `Req*` inputs.
- If `Req[i]` drops after grant, the frame still completes and `Ack[i]` is still issued.
- Requests arriving during a frame wait; there is no queueing beyond the level `Req` lines.
- `TxActive` and `TxDone` are ignored in IDLE, SETUP, DONE and FAIL.
- Timeout counter width is clog2(`TIMEOUT`+1) bits. It clears on START entry and saturates rather than wrapping.

## Timing
- `Req` first high at edge t (state IDLE, none pending):
  - `Grant` and `Tx*` data/config valid from t+1 (SETUP).
  - `TxSend` high from t+2.
- `TxSend` falls on the edge after `TxActive` is sampled high.
- `Ack` is high for exactly the cycle after the BUSY exit condition is sampled.
- Back-to-back: with another `Req` pending, the next `Grant` appears 2 cycles after `Ack` (DONE→IDLE→SETUP).
- Timeout: if `TxActive` never rises, `Err` is high exactly `TIMEOUT`+1 cycles after `TxSend` first went high.
- `Grant` and `Busy` are never high in IDLE. At most one bit of `Grant`, `Ack` and `Err` is high in any cycle.

## Test plan
- Reset, single request: `Reset` for 2 cycles; every output reads 0. Then `Req`=0001, byte 0xA5, parity 01, baud 10. Required: `Grant`=0001 and `TxData`=0xA5 one cycle before `TxSend` rises; serial frame completes; one `Ack`=0001 pulse; `Busy`=0 afterwards.
- All four requesters held high with bytes 0x11/0x22/0x33/0x44. Required service order: 0→1→2→3→0. Frames go out as 0x11, 0x22, 0x33, 0x44, 0x11; each next `Grant` appears 2 cycles after the previous `Ack`.
- Simultaneous requests 1 and 3 with pointer=2. Required: 3 is served first; pointer wraps to 0; then 1 is served.
- Stubbed Tx unit with `TxActive` tied to 0, `TIMEOUT`=15, `Req`=0100. Required: `TxSend` high for 16 cycles; `Err`=0100 for one cycle; no `Ack`; pointer=3.
- Mid-frame: `Req[0]` dropped during BUSY, and `ReqData` changed during START. Required: the transmitted byte equals the value latched at grant; `Ack[0]` is still pulsed.
- `Reset` asserted during BUSY. Required: next cycle `TxSend`=0, `Grant`=0, state IDLE; no `Ack` or `Err`; pointer=0.
